cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Multi-cycle controller that drives the combinational CU (19-bit instruction in, 8-bit result out).
- Fetches instructions from a synchronous instruction memory starting at a programmable base address and presents each one to the CU.
- Registers each CU result and hands it downstream on a valid/ready port.
- Runs until a HALT opcode or the end of the address space, then reports done.

Parameters:
- ADDR_W, 8, instruction memory address width.
- INSTR_W, 19, instruction width. Layout: opcode [18:16], operand A [15:8], operand B [7:0]. Fixed at 19 because the CU decodes it.
- DATA_W, 8, CU result width. Fixed at 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE or DONE.
- base_addr  in  ADDR_W  first instruction address; captured on accepted start.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  ADDR_W  instruction memory read address.
- imem_rdata  in  INSTR_W  instruction word; valid the cycle after imem_en.
- cu_instr  out  INSTR_W  registered instruction driven to the CU.
- cu_result  in  DATA_W  combinational CU output.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DATA_W  registered CU result.
- res_addr  out  ADDR_W  address of the instruction that produced res_data.
- busy  out  1  high in FETCH, LOAD, EXEC and OUT.
- done  out  1  high in DONE.
- instr_count  out  ADDR_W+1  results accepted in the current run.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - pc, cu_instr, res_data, res_addr, instr_count = 0.
  - res_valid, imem_en, busy, done = 0.
  - Reset mid-run aborts immediately; no partial result survives.
- IDLE:
  - start=1 -> pc<=base_addr, instr_count<=0, go to FETCH.
  - Otherwise remain in IDLE.
- FETCH:
  - imem_en=1 and imem_addr=pc for exactly this cycle.
  - Next state is LOAD.
  - imem_en is 0 in every other state.
- LOAD:
  - imem_rdata is valid; cu_instr<=imem_rdata.
  - If imem_rdata[18:16]==3'b000 (HALT), go to DONE; no result is emitted for HALT.
  - Otherwise go to EXEC.
- EXEC:
  - The CU sees the stable cu_instr.
  - At the clock edge: res_data<=cu_result, res_addr<=pc, res_valid<=1, go to OUT.
- OUT:
  - res_valid, res_data and res_addr hold stable until res_ready=1 is sampled with res_valid=1.
  - On that handshake: res_valid<=0, instr_count<=instr_count+1.
  - Then, if pc is all ones, go to DONE (no wrap-around). Otherwise pc<=pc+1 and go to FETCH.
- DONE:
  - done=1, busy=0; instr_count and last res_data/res_addr are held.
  - start=1 begins a new run exactly as from IDLE.
- start is ignored while busy=1.
- Latency: the start edge to res_valid rising is 4 clock edges (FETCH, LOAD, EXEC, then OUT entered).
- Minimum throughput is one result per 4 cycles with res_ready tied high.
- res_ready while res_valid=0 has no effect.
- cu_instr is a register output; it changes only in LOAD and on reset.

Test Plan:
1. Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately. Release -> state IDLE, no imem_en.
2. Single instruction:
   - Setup: mem[0]=19'b0010010001100010100, mem[1]=HALT, res_ready=1, base_addr=0, start pulse.
   - Required: imem_en high one cycle with addr 0; res_valid rises on the 4th edge after start; res_data equals the CU model for opcode 001 with A=0x23, B=0x14; res_addr=0.
   - Then: done=1 and instr_count=1.
3. Backpressure:
   - Setup: as scenario 2, but res_ready=0 for 5 cycles after res_valid.
   - Required: res_valid, res_data and res_addr stay constant, and imem_en stays 0.
   - Release res_ready=1 -> one handshake, instr_count=1.
4. Opcode sweep:
   - Setup: mem[0..6] hold opcodes 001..111 with A=0x23, B=0x14; mem[7]=HALT.
   - Required: 7 results at res_addr 0..6, each matching the CU model; done=1; instr_count=7.
5. End of address space:
   - Setup: base_addr=8'hFE, mem[FE] and mem[FF] non-HALT.
   - Required: results at FE then FF, then done=1 with no fetch at address 00; instr_count=2.
6. Reset and restart:
   - Start during busy -> no effect.
   - rst_n low while in OUT -> res_valid=0 at once.
   - A new start after release -> run restarts from the new base_addr.

Source files
------------

// File: rtl/cu_sequencer_if.sv
// Sequencer-side bus bundle: instruction memory read port, CU instruction/result
// pair, and the valid/ready result port toward downstream.
interface cu_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 19,
  parameter int unsigned DATA_W  = 8
);
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] cu_instr;
  logic [DATA_W-1:0]  cu_result;
  logic               res_valid;
  logic               res_ready;
  logic [DATA_W-1:0]  res_data;
  logic [ADDR_W-1:0]  res_addr;

  modport master (
    output imem_en, imem_addr, cu_instr, res_valid, res_data, res_addr,
    input  imem_rdata, cu_result, res_ready
  );

  modport slave (
    input  imem_en, imem_addr, cu_instr, res_valid, res_data, res_addr,
    output imem_rdata, cu_result, res_ready
  );
endinterface

// File: rtl/cu_sequencer.sv
// Multi-cycle controller: fetches instructions from a synchronous memory, runs them
// through the combinational CU and emits each registered result on a valid/ready port.
module cu_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 19,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  cu_sequencer_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [2:0] OP_HALT = 3'b000;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, OUT, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  res_addr_q, res_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               en_q, busy_q, done_q;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    res_addr_d = res_addr_q;
    instr_d    = instr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = base_addr;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        instr_d = bus.imem_rdata;
        state_d = (bus.imem_rdata[INSTR_W-1 -: 3] == OP_HALT) ? DONE : EXEC;
      end
      EXEC: begin
        data_d     = bus.cu_result;
        res_addr_d = pc_q;
        valid_d    = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (valid_q && bus.res_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
          // The address space does not wrap: the last word ends the run.
          if (&pc_q) begin
            state_d = DONE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; status flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      res_addr_q <= '0;
      instr_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      res_addr_q <= res_addr_d;
      instr_q    <= instr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      en_q       <= (state_d == FETCH);
      busy_q     <= (state_d == FETCH) || (state_d == LOAD) ||
                    (state_d == EXEC)  || (state_d == OUT);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.imem_en   = en_q;
  assign bus.imem_addr = pc_q;
  assign bus.cu_instr  = instr_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;
  assign bus.res_addr  = res_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: memory and CU models, scoreboard on the result port,
// an opcode vector table and hand-written corner-case sequences.
module tb_cu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic       busy;
  logic       done;
  logic [8:0] instr_count;

  cu_sequencer_if #(.ADDR_W(8), .INSTR_W(19), .DATA_W(8)) bus ();

  cu_sequencer #(.ADDR_W(8), .INSTR_W(19), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-defined CU behaviour
  function automatic logic [7:0] cu_fn(input logic [18:0] i);
    logic [7:0] a, b;
    a = i[15:8];
    b = i[7:0];
    case (i[18:16])
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return {a[3:0], a[7:4]};
      3'd5:    return b - a;
      3'd6:    return ~a;
      3'd7:    return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.cu_result = cu_fn(bus.cu_instr);

  logic [18:0] mem [256];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} exp_t;
  exp_t sb[$];
  exp_t sb_e;

  // Scoreboard: handshake will occur at the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        sb_e = sb.pop_front();
        check("sb_addr", 32'(bus.res_addr), 32'(sb_e.addr));
        check("sb_data", 32'(bus.res_data), 32'(sb_e.data));
      end
    end
  end

  logic fetched_zero;
  always @(negedge clk) if (bus.imem_en && bus.imem_addr == 8'h00) fetched_zero = 1'b1;

  typedef struct {logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] exp;} vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.res_valid && n < 50) begin tick(); n++; end
    check(name, 32'(bus.res_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hold_data, hold_addr;
    logic       stable;
    vecs[0] = '{3'd1, 8'h23, 8'h14, 8'h37};
    vecs[1] = '{3'd2, 8'h23, 8'h14, 8'h0F};
    vecs[2] = '{3'd3, 8'h23, 8'h14, 8'h00};
    vecs[3] = '{3'd4, 8'h23, 8'h14, 8'h32};
    vecs[4] = '{3'd5, 8'h23, 8'h14, 8'hF1};
    vecs[5] = '{3'd6, 8'h23, 8'h14, 8'hDC};
    vecs[6] = '{3'd7, 8'h23, 8'h14, 8'h11};
    for (int i = 0; i < 256; i++) mem[i] = 19'h0;

    // Reset asserted asynchronously, away from any edge
    rst_n = 1'b1; start = 1'b0; base_addr = 8'h00; bus.res_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_imem_en", 32'(bus.imem_en), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_regs", 32'({bus.cu_instr, bus.res_data, bus.res_addr, instr_count}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("idle_no_fetch", 32'({bus.imem_en, busy, done}), 32'd0);

    // Single instruction, latency
    mem[0] = 19'b0010010001100010100;
    mem[1] = 19'h0;
    bus.res_ready = 1'b1;
    sb.push_back('{8'h00, 8'h37});
    pulse_start(8'h00);
    check("s2_fetch_en", 32'(bus.imem_en), 32'd1);
    check("s2_fetch_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    check("s2_fetch_one_cycle", 32'(bus.imem_en), 32'd0);
    tick();
    check("s2_valid_early", 32'(bus.res_valid), 32'd0);
    tick();
    check("s2_valid_4th_edge", 32'(bus.res_valid), 32'd1);
    check("s2_data", 32'(bus.res_data), 32'h37);
    check("s2_addr", 32'(bus.res_addr), 32'h00);
    wait_done("s2_done");
    check("s2_count", 32'(instr_count), 32'd1);
    check("s2_busy", 32'(busy), 32'd0);

    // Backpressure
    bus.res_ready = 1'b0;
    sb.push_back('{8'h00, 8'h37});
    pulse_start(8'h00);
    check("s3_count_cleared", 32'(instr_count), 32'd0);
    wait_valid("s3_valid");
    hold_data = bus.res_data;
    hold_addr = bus.res_addr;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.res_valid || bus.res_data != hold_data || bus.res_addr != hold_addr || bus.imem_en)
        stable = 1'b0;
    end
    check("s3_hold_stable", 32'(stable), 32'd1);
    check("s3_hold_data", 32'(hold_data), 32'h37);
    bus.res_ready = 1'b1;
    tick();
    check("s3_valid_dropped", 32'(bus.res_valid), 32'd0);
    wait_done("s3_done");
    check("s3_count", 32'(instr_count), 32'd1);

    // Opcode sweep from the vector table
    for (int i = 0; i < 7; i++) begin
      mem[i] = {vecs[i].op, vecs[i].a, vecs[i].b};
      sb.push_back('{8'(i), vecs[i].exp});
    end
    mem[7] = 19'h0;
    pulse_start(8'h00);
    for (int i = 0; i < 7; i++) begin
      wait_valid("s4_valid");
      check("s4_addr", 32'(bus.res_addr), 32'(i));
      check("s4_data", 32'(bus.res_data), 32'(vecs[i].exp));
      tick();
    end
    wait_done("s4_done");
    check("s4_count", 32'(instr_count), 32'd7);

    // End of address space: no wrap to address 0
    mem[8'hFE] = {3'd1, 8'h01, 8'h02};
    mem[8'hFF] = {3'd6, 8'h0F, 8'h00};
    mem[8'h00] = {3'd1, 8'h10, 8'h10};
    sb.push_back('{8'hFE, 8'h03});
    sb.push_back('{8'hFF, 8'hF0});
    fetched_zero = 1'b0;
    pulse_start(8'hFE);
    wait_done("s5_done");
    tick(); tick();
    check("s5_no_wrap_fetch", 32'(fetched_zero), 32'd0);
    check("s5_count", 32'(instr_count), 32'd2);
    check("s5_last_addr", 32'(bus.res_addr), 32'hFF);

    // Start ignored while busy, reset in OUT, restart from a new base
    mem[8'h10] = {3'd2, 8'h50, 8'h10};
    mem[8'h11] = 19'h0;
    mem[8'h20] = {3'd7, 8'hAA, 8'h00};
    mem[8'h21] = 19'h0;
    bus.res_ready = 1'b0;
    pulse_start(8'h10);
    pulse_start(8'h20);
    wait_valid("s6_valid");
    check("s6_start_ignored", 32'(bus.res_addr), 32'h10);
    check("s6_data", 32'(bus.res_data), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(bus.res_valid), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_data", 32'(bus.res_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.res_ready = 1'b1;
    sb.push_back('{8'h20, 8'h55});
    pulse_start(8'h20);
    wait_done("s6_done");
    check("s6_count", 32'(instr_count), 32'd1);
    check("s6_addr", 32'(bus.res_addr), 32'h20);
    check("s6_data2", 32'(bus.res_data), 32'h55);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
